pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter and fetch-control stage of the single-cycle MIPS CPU. Sits upstream of the instruction ROM and the register-address mux; it supplies the ROM word address and PC+4 (the jal link value).
- Computes next PC from branch/jump/jr controls.
- Implements the syscall halt/resume state machine driven by the $v0 value and the Go button.
- Keeps run statistics: executed cycles, jumps, taken branches.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
CONT_CODE, 32'h00000022, $v0 value for which syscall does not halt
IMEM_AW, 10, instruction ROM word-address width
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
instr  input  32  current instruction word from ROM
v0_val  input  32  register-file read data for $v0 (valid when syscall=1)
syscall  input  1  decoded syscall
go  input  1  one-cycle resume pulse (debounced elsewhere)
branch_taken  input  1  conditional branch taken this cycle
jump  input  1  j or jal
jr  input  1  jr
jr_target  input  32  rs read data for jr
pc_out  output  32  current PC
pc_plus4  output  32  PC+4 (combinational)
imem_addr  output  IMEM_AW  pc_out[IMEM_AW+1:2]
halted  output  1  1 while in HALT
cycle_cnt  output  CNT_W  count of PC-advancing cycles
jmp_cnt  output  CNT_W  count of advancing cycles with jump or jr
br_cnt  output  CNT_W  count of advancing cycles with branch_taken
align_fault  output  1  sticky misaligned-jr flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-low on `rst_n`, sampled on the rising edge of `clk`. Reset has priority over all other inputs, including mid-halt and same-cycle go.
- Reset values: pc=RESET_PC, state=RUN, halted=0, all counters=0, align_fault=0.
- Next PC is selected by priority jr > jump > branch_taken > sequential:
  - jr: jr_target.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch: pc_plus4 + (sign-extended instr[15:0] << 2), 32-bit wrap.
  - otherwise: pc_plus4, 32-bit wrap (32'hFFFFFFFC -> 0).
- "advance" is true when the PC register loads the next PC this edge.
- FSM states:
  - RUN:
    - If syscall=1, v0_val!=CONT_CODE and go=0: go to HALT. PC holds (stays on the syscall), advance=0.
    - Otherwise advance=1.
    - go=1 coincident with a halting syscall passes through without halting.
  - HALT:
    - halted=1, PC and all counters frozen.
    - go=1: advance=1 using normal next-PC (normally pc+4 past the syscall), return to RUN.
    - go=0: remain in HALT.
- Counters:
  - Update only when advance=1.
  - cycle_cnt +1.
  - jmp_cnt +1 if jump|jr.
  - br_cnt +1 if branch_taken and not jump|jr.
  - All counters saturate at all-ones; no wrap.
- Latency: pc_out and counters reflect the edge after the causing inputs. halted asserts the cycle after the halting syscall edge.
- Other inputs are ignored while in HALT, except that the halting decision is not re-evaluated.

Optional Feature:
Macro: PC_ALIGN_TRAP_EN.
- Defined: a jr with jr_target[1:0]!=0, in a cycle that would otherwise advance:
  - does not update the PC;
  - sets align_fault=1 (sticky) and enters HALT;
  - go is ignored while align_fault=1; only reset clears it.
- Undefined: jr_target[1:0] is forced to 2'b00 and execution proceeds; align_fault is tied to 0.

Test Plan:
- Reset/sequential: hold rst_n=0 2 cycles, release, no controls for 4 cycles -> pc_out 0,4,8,C,10; cycle_cnt=4; imem_addr=4 at pc=0x10.
- Branch/jump targets:
  - pc=0x20, branch_taken, instr[15:0]=16'hFFFE -> pc=0x1C.
  - pc=0x1C, jump, instr[25:0]=26'h40 -> pc=0x100; jmp_cnt=1, br_cnt=1.
  - Priority: jr=1 and jump=1 with jr_target=0x200 -> pc=0x200.
- Syscall halt/resume:
  - syscall with v0_val=10 at pc=0x30 -> halted=1, pc stays 0x30 for 5 idle cycles, counters frozen.
  - go pulse -> pc=0x34, halted=0.
- Continue code and coincident go:
  - syscall with v0_val=0x22 -> no halt, pc advances.
  - syscall with v0_val=10 and go=1 same cycle -> no halt.
- Reset mid-halt: halted=1, assert rst_n=0 with go=1 -> pc=RESET_PC, halted=0, counters=0.
- Alignment/saturation:
  - Macro defined: jr_target=0x103 -> align_fault=1, pc held, go ignored.
  - Macro undefined: jr_target=0x103 -> pc=0x100.
  - CNT_W=4 over 20 advancing cycles -> cycle_cnt stays 4'hF.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC select, syscall halt FSM and run statistics
//
// Purpose:
//   Fetch-control stage of the single-cycle MIPS core. Holds the PC, selects the
//   next PC (jr > jump > taken branch > sequential), halts on a syscall whose
//   $v0 is not the continue code until a go pulse, and counts advancing cycles,
//   jumps and taken branches with saturating counters.
//
// Configuration:
//   PC_ALIGN_TRAP_EN - when defined, a jr to a non word-aligned target traps:
//                      the PC holds, align_fault latches and the unit halts
//                      until reset. When undefined, jr_target[1:0] is dropped.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   instr        in   current instruction word from ROM
//   v0_val       in   $v0 read data, meaningful when syscall=1
//   syscall      in   decoded syscall
//   go           in   one-cycle resume pulse
//   branch_taken in   conditional branch taken this cycle
//   jump         in   j or jal
//   jr           in   jr
//   jr_target    in   rs read data for jr
//   pc_out       out  current PC
//   pc_plus4     out  PC+4, combinational (jal link value)
//   imem_addr    out  instruction ROM word address
//   halted       out  1 while in HALT
//   cycle_cnt    out  count of PC-advancing cycles
//   jmp_cnt      out  count of advancing cycles with jump or jr
//   br_cnt       out  count of advancing cycles with a taken branch (no jump/jr)
//   align_fault  out  sticky misaligned-jr flag

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] CONT_CODE = 32'h0000_0022,
  parameter int          IMEM_AW   = 10,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic [31:0]        v0_val,
  input  logic               syscall,
  input  logic               go,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic               jr,
  input  logic [31:0]        jr_target,
  output logic [31:0]        pc_out,
  output logic [31:0]        pc_plus4,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   jmp_cnt,
  output logic [CNT_W-1:0]   br_cnt,
  output logic               align_fault
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pc_q;
  logic [0:0]  state_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] jmp_q;
  logic [CNT_W-1:0] br_q;
  logic        fault_q;

  logic [31:0] br_offset;
  logic [31:0] jr_eff;
  logic [31:0] next_pc;
  logic        halt_req;
  logic        would_advance;
  logic        align_bad;
  logic        advance;
  logic        is_jmp;

  // ---------------------------------------------------------------------------
  // Next-PC datapath
  // ---------------------------------------------------------------------------
  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

`ifdef PC_ALIGN_TRAP_EN
  assign jr_eff    = jr_target;
  assign align_bad = jr && (jr_target[1:0] != 2'b00);
`else
  // Low bits dropped so the PC can never become misaligned.
  assign jr_eff    = {jr_target[31:2], 2'b00};
  assign align_bad = 1'b0;
  logic unused_jr_low;
  assign unused_jr_low = &{1'b0, jr_target[1:0]};
`endif

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_eff;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + br_offset;
    end
  end

  logic unused_instr_hi;
  assign unused_instr_hi = &{1'b0, instr[31:26]};

  // ---------------------------------------------------------------------------
  // Halt / resume control
  // ---------------------------------------------------------------------------
  // A go coincident with a halting syscall lets the syscall pass straight through.
  assign halt_req = syscall && (v0_val != CONT_CODE) && !go;

  always_comb begin
    would_advance = 1'b0;
    if (state_q == ST_RUN) begin
      would_advance = !halt_req;
    end else begin
      // Once an alignment trap has fired, only reset gets the core going again.
      would_advance = go && !fault_q;
    end
  end

  // A misaligned jr vetoes the advance and diverts into HALT instead.
  assign advance = would_advance && !align_bad;
  assign is_jmp  = jump || jr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            state_q <= ST_HALT;
          end else if (align_bad) begin
            state_q <= ST_HALT;
            fault_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (would_advance) begin
            if (align_bad) begin
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PC register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (advance) begin
      pc_q <= next_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating run statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q <= '0;
      jmp_q   <= '0;
      br_q    <= '0;
    end else if (advance) begin
      if (cycle_q != CNT_MAX) begin
        cycle_q <= cycle_q + CNT_ONE;
      end
      if (is_jmp && (jmp_q != CNT_MAX)) begin
        jmp_q <= jmp_q + CNT_ONE;
      end
      // jump/jr overrides the branch, so it is not counted as a taken branch.
      if (branch_taken && !is_jmp && (br_q != CNT_MAX)) begin
        br_q <= br_q + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_out    = pc_q;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign halted    = (state_q == ST_HALT);
  assign cycle_cnt = cycle_q;
  assign jmp_cnt   = jmp_q;
  assign br_cnt    = br_q;

`ifdef PC_ALIGN_TRAP_EN
  assign align_fault = fault_q;
`else
  assign align_fault = 1'b0;
  logic unused_fault;
  assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed table-driven bench for pc_fetch_unit

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] v0_val;
  logic        syscall;
  logic        go;
  logic        branch_taken;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;

  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [9:0]  imem_addr;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] jmp_cnt;
  logic [31:0] br_cnt;
  logic        align_fault;

  logic [31:0] s_pc_out;
  logic [31:0] s_pc_plus4;
  logic [9:0]  s_imem_addr;
  logic        s_halted;
  logic [3:0]  s_cycle_cnt;
  logic [3:0]  s_jmp_cnt;
  logic [3:0]  s_br_cnt;
  logic        s_align_fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .v0_val(v0_val),
    .syscall(syscall), .go(go), .branch_taken(branch_taken), .jump(jump),
    .jr(jr), .jr_target(jr_target), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .imem_addr(imem_addr), .halted(halted), .cycle_cnt(cycle_cnt),
    .jmp_cnt(jmp_cnt), .br_cnt(br_cnt), .align_fault(align_fault)
  );

  pc_fetch_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instr(instr), .v0_val(v0_val),
    .syscall(syscall), .go(go), .branch_taken(branch_taken), .jump(jump),
    .jr(jr), .jr_target(jr_target), .pc_out(s_pc_out), .pc_plus4(s_pc_plus4),
    .imem_addr(s_imem_addr), .halted(s_halted), .cycle_cnt(s_cycle_cnt),
    .jmp_cnt(s_jmp_cnt), .br_cnt(s_br_cnt), .align_fault(s_align_fault)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] v0;
    logic        sc;
    logic        go;
    logic        br;
    logic        j;
    logic        jr;
    logic [31:0] jt;
    logic [31:0] pc;
    logic        h;
    logic [31:0] cyc;
    logic [31:0] jc;
    logic [31:0] bc;
    logic        af;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  function automatic vec_t mk(logic [31:0] i_instr, logic [31:0] i_v0, logic i_sc,
                              logic i_go, logic i_br, logic i_j, logic i_jr,
                              logic [31:0] i_jt, logic [31:0] e_pc, logic e_h,
                              logic [31:0] e_cyc, logic [31:0] e_jc,
                              logic [31:0] e_bc, logic e_af);
    vec_t v;
    v.instr = i_instr; v.v0 = i_v0; v.sc = i_sc; v.go = i_go; v.br = i_br;
    v.j = i_j; v.jr = i_jr; v.jt = i_jt; v.pc = e_pc; v.h = e_h;
    v.cyc = e_cyc; v.jc = e_jc; v.bc = e_bc; v.af = e_af;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    instr = 32'h0; v0_val = 32'h0; syscall = 1'b0; go = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          instr         v0     sc go br j  jr jt             pc             h  cyc jc bc af
    tv[0]  = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h04,        0, 1,  0, 0, 0);
    tv[1]  = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h08,        0, 2,  0, 0, 0);
    tv[2]  = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h0C,        0, 3,  0, 0, 0);
    tv[3]  = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h10,        0, 4,  0, 0, 0);
    tv[4]  = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h14,        0, 5,  0, 0, 0);
    tv[5]  = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h18,        0, 6,  0, 0, 0);
    tv[6]  = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h1C,        0, 7,  0, 0, 0);
    tv[7]  = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h20,        0, 8,  0, 0, 0);
    // backward branch: 0x24 + (-2 << 2) = 0x1C
    tv[8]  = mk(32'h0000FFFE, 32'd0, 0, 0, 1, 0, 0, 32'h0,         32'h1C,        0, 9,  0, 1, 0);
    // jump wins over branch; branch not counted
    tv[9]  = mk(32'h08000040, 32'd0, 0, 0, 1, 1, 0, 32'h0,         32'h100,       0, 10, 1, 1, 0);
    // jr wins over jump
    tv[10] = mk(32'h08000040, 32'd0, 0, 0, 0, 1, 1, 32'h200,       32'h200,       0, 11, 2, 1, 0);
    tv[11] = mk(32'h0,        32'd0, 0, 0, 0, 0, 1, 32'h30,        32'h30,        0, 12, 3, 1, 0);
    // halting syscall: PC stays, halted next cycle
    tv[12] = mk(32'h0,        32'd10, 1, 0, 0, 0, 0, 32'h0,        32'h30,        1, 12, 3, 1, 0);
    tv[13] = mk(32'h0000FFFE, 32'd0, 0, 0, 1, 0, 0, 32'h0,         32'h30,        1, 12, 3, 1, 0);
    tv[14] = mk(32'h0,        32'h22, 1, 0, 0, 0, 0, 32'h0,        32'h30,        1, 12, 3, 1, 0);
    tv[15] = mk(32'h0,        32'd0, 0, 0, 0, 1, 1, 32'h400,       32'h30,        1, 12, 3, 1, 0);
    tv[16] = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h30,        1, 12, 3, 1, 0);
    tv[17] = mk(32'h0,        32'd0, 0, 0, 0, 0, 0, 32'h0,         32'h30,        1, 12, 3, 1, 0);
    tv[18] = mk(32'h0,        32'd0, 0, 1, 0, 0, 0, 32'h0,         32'h34,        0, 13, 3, 1, 0);
    // continue code: no halt
    tv[19] = mk(32'h0,        32'h22, 1, 0, 0, 0, 0, 32'h0,        32'h38,        0, 14, 3, 1, 0);
    // halting code with coincident go: no halt
    tv[20] = mk(32'h0,        32'd10, 1, 1, 0, 0, 0, 32'h0,        32'h3C,        0, 15, 3, 1, 0);
`ifdef PC_ALIGN_TRAP_EN
    tv[21] = mk(32'h0,        32'd0, 0, 0, 0, 0, 1, 32'h103,       32'h3C,        1, 15, 3, 1, 1);
    tv[22] = mk(32'h0,        32'd0, 0, 1, 0, 0, 0, 32'h0,         32'h3C,        1, 15, 3, 1, 1);
`else
    tv[21] = mk(32'h0,        32'd0, 0, 0, 0, 0, 1, 32'h103,       32'h100,       0, 16, 4, 1, 0);
    tv[22] = mk(32'h0,        32'd0, 0, 1, 0, 0, 0, 32'h0,         32'h104,       0, 17, 4, 1, 0);
`endif

    idle_inputs();
    rst_n = 1'b0;
    step();
    step();

    check("reset_pc",        pc_out,      32'h0);
    check("reset_halted",    {31'b0, halted}, 32'h0);
    check("reset_cycle",     cycle_cnt,   32'h0);
    check("reset_jmp",       jmp_cnt,     32'h0);
    check("reset_br",        br_cnt,      32'h0);
    check("reset_align",     {31'b0, align_fault}, 32'h0);
    check("reset_pc_plus4",  pc_plus4,    32'h4);

    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      instr = tv[i].instr; v0_val = tv[i].v0; syscall = tv[i].sc; go = tv[i].go;
      branch_taken = tv[i].br; jump = tv[i].j; jr = tv[i].jr; jr_target = tv[i].jt;
      step();
      check($sformatf("v%0d_pc", i),     pc_out,    tv[i].pc);
      check($sformatf("v%0d_imem", i),   {22'b0, imem_addr}, {22'b0, tv[i].pc[11:2]});
      check($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, tv[i].h});
      check($sformatf("v%0d_cycle", i),  cycle_cnt, tv[i].cyc);
      check($sformatf("v%0d_jmp", i),    jmp_cnt,   tv[i].jc);
      check($sformatf("v%0d_br", i),     br_cnt,    tv[i].bc);
      check($sformatf("v%0d_align", i),  {31'b0, align_fault}, {31'b0, tv[i].af});
    end

    // Reset while halted, with go asserted in the same cycle
    idle_inputs();
    syscall = 1'b1; v0_val = 32'd10;
    step();
    check("pre_rst_halted", {31'b0, halted}, 32'h1);
    idle_inputs();
    rst_n = 1'b0; go = 1'b1;
    step();
    check("midhalt_rst_pc",     pc_out,    32'h0);
    check("midhalt_rst_halted", {31'b0, halted}, 32'h0);
    check("midhalt_rst_cycle",  cycle_cnt, 32'h0);
    check("midhalt_rst_jmp",    jmp_cnt,   32'h0);
    check("midhalt_rst_align",  {31'b0, align_fault}, 32'h0);
    rst_n = 1'b1; go = 1'b0;

    // Sequential wrap at the top of the address space
    jr = 1'b1; jr_target = 32'hFFFF_FFFC;
    step();
    check("wrap_pc_top",   pc_out,   32'hFFFF_FFFC);
    check("wrap_plus4",    pc_plus4, 32'h0);
    idle_inputs();
    step();
    check("wrap_pc_zero",  pc_out,   32'h0);

    // Counter saturation on the 4-bit instance
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
    end
    check("sat_cycle_4b",  {28'b0, s_cycle_cnt}, 32'hF);
    check("sat_ref_cycle", cycle_cnt, 32'd20);
    check("sat_ref_pc",    pc_out,    32'h50);
    check("sat_pc_4b",     s_pc_out,  32'h50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
